// File: rtl/hht_control.sv
// HHT gather engine: walks a column-index array, fetches the matching dense-vector
// words through a two-stage pipeline and queues (value, index) pairs for CPU pops.
module hht_control #(
  parameter int          BUF_DEPTH     = 9,
  parameter logic [31:0] HHT_PORT_ADDR = 32'd126
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] wdata_col_base,
  input  logic [31:0] v_values_base,
  input  logic [31:0] csize,
  output logic [31:0] addr1,
  input  logic [31:0] dataIn1,
  output logic [31:0] addr2,
  input  logic [31:0] dataIn2,
  input  logic        RD,
  input  logic [31:0] cpu_addr,
  output logic        hht,
  output logic [31:0] rdata,
  output logic [31:0] adata,
  output logic [31:0] regaddr1,
  output logic [31:0] regaddr2
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] col;
    logic [31:0] a1;
    logic [31:0] a2;
  } entry_t;

  state_t        state;
  entry_t        fifo_mem [0:BUF_DEPTH-1];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          s1_valid;
  logic [31:0]   s1_col, s1_addr1;
  logic [31:0]   v_base_q, size_q, issued, popped;
  logic [CW:0]   occ_sum;
  logic          issue, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The stage-1 element counts as occupied so a stalled consumer can never overflow the buffer.
  assign occ_sum = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign issue   = (state == FETCH) && (occ_sum < DEPTH_L);
  assign push    = s1_valid;
  assign pop     = RD && (cpu_addr == HHT_PORT_ADDR) && (count != '0);

  // NOTE: the buffer storage carries no reset; clearing the pointers and count is enough
  // to make stale entries unreachable, and it keeps the array a plain RAM.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= '{value: dataIn2, col: s1_col, a1: s1_addr1, a2: addr2};
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, which is what lets issue, push and pop share one edge safely.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      addr1    <= '0;
      addr2    <= '0;
      hht      <= 1'b0;
      rdata    <= '0;
      adata    <= '0;
      regaddr1 <= '0;
      regaddr2 <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_addr1 <= '0;
      v_base_q <= '0;
      size_q   <= '0;
      issued   <= '0;
      popped   <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_col   <= dataIn1;
        s1_addr1 <= addr1;
        addr2    <= v_base_q + dataIn1;
        addr1    <= addr1 + 32'd1;
        issued   <= issued + 32'd1;
      end

      if (push) wr_ptr <= next_ptr(wr_ptr);

      if (pop) begin
        rdata    <= fifo_mem[rd_ptr].value;
        adata    <= fifo_mem[rd_ptr].col;
        regaddr1 <= fifo_mem[rd_ptr].a1;
        regaddr2 <= fifo_mem[rd_ptr].a2;
        rd_ptr   <= next_ptr(rd_ptr);
        popped   <= popped + 32'd1;
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          size_q   <= csize;
          v_base_q <= v_values_base;
          if (csize == '0) begin
            state <= DONE;
          end else begin
            addr1 <= wdata_col_base;
            hht   <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (issue && (issued + 32'd1 == size_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (popped + 32'd1 == size_q)) begin
            hht   <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_hht_control.sv
// Self-checking bench for hht_control: memory model plus an expected-stream model
// derived directly from the gather rule value = mem[v_base + mem[col_base + k]].
module tb_hht_control;

  localparam int MEM_WORDS = 512;
  localparam int COL_BASE  = 180;
  localparam int V_BASE    = 2;
  localparam int N         = 230;
  localparam int LIMIT     = 4000;
  localparam int OOR_K     = 100;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] wdata_col_base, v_values_base, csize;
  logic [31:0] addr1, addr2, dataIn1, dataIn2;
  logic        RD;
  logic [31:0] cpu_addr;
  logic        hht;
  logic [31:0] rdata, adata, regaddr1, regaddr2;

  logic [31:0] mem [0:MEM_WORDS-1];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] oor_seen;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return (a < MEM_WORDS) ? mem[a[8:0]] : 32'd99999;
  endfunction

  assign dataIn1 = rd_mem(addr1);
  assign dataIn2 = rd_mem(addr2);

  hht_control #(.BUF_DEPTH(9), .HHT_PORT_ADDR(32'd126)) dut (
    .Clk(Clk), .Rst(Rst),
    .wdata_col_base(wdata_col_base), .v_values_base(v_values_base), .csize(csize),
    .addr1(addr1), .dataIn1(dataIn1), .addr2(addr2), .dataIn2(dataIn2),
    .RD(RD), .cpu_addr(cpu_addr), .hht(hht),
    .rdata(rdata), .adata(adata), .regaddr1(regaddr1), .regaddr2(regaddr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected k-th popped element, straight from the gather definition.
  function automatic logic [31:0] exp_col(input int k);
    return mem[COL_BASE + k];
  endfunction
  function automatic logic [31:0] exp_a2(input int k);
    return V_BASE + exp_col(k);
  endfunction

  task automatic check_elem(input string tag, input int k);
    check({tag, ".rdata"},    rdata,    rd_mem(exp_a2(k)));
    check({tag, ".adata"},    adata,    exp_col(k));
    check({tag, ".regaddr1"}, regaddr1, COL_BASE + k);
    check({tag, ".regaddr2"}, regaddr2, exp_a2(k));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".addr1"},    addr1,    0);
    check({tag, ".addr2"},    addr2,    0);
    check({tag, ".rdata"},    rdata,    0);
    check({tag, ".adata"},    adata,    0);
    check({tag, ".regaddr1"}, regaddr1, 0);
    check({tag, ".regaddr2"}, regaddr2, 0);
    check({tag, ".hht"},      hht,      0);
  endtask

  task automatic load_mem();
    int v [16] = '{7, 93, 68, 80, 90, 15, 4, 8, 35, 81, 45, 52, 48, 69, 100, 34};
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[V_BASE + i] = v[i];
    for (int k = 0; k < N; k++) mem[COL_BASE + k] = $urandom_range(0, 15);
    mem[180] = 15;
    mem[181] = 2;
    mem[182] = 11;
    mem[409] = 3;
  endtask

  // Reset held for two edges, released just after an edge so the next edge is E1.
  task automatic do_reset();
    Rst = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
  endtask

  // Random-consumer drain: a pop is detected by regaddr1 moving (it is unique per element).
  task automatic drain(input string tag, input int start, input int rd_pct, input int wrong_pct);
    int popped = start;
    int cycles = 0;
    logic [31:0] prev_r1 = regaddr1;
    logic req;
    while (popped < N && cycles < LIMIT) begin
      RD       = ($urandom_range(0, 99) < rd_pct);
      cpu_addr = ($urandom_range(0, 99) < wrong_pct) ? 32'd125 : 32'd126;
      req      = RD && (cpu_addr == 32'd126);
      tick();
      cycles++;
      if (regaddr1 !== prev_r1) begin
        check({tag, ".pop_needs_req"}, req, 1);
        check_elem(tag, popped);
        if (popped == OOR_K) oor_seen = rdata;
        popped++;
        prev_r1 = regaddr1;
      end
      check({tag, ".issue_bound"}, (addr1 - COL_BASE) <= popped + 9, 1);
      check({tag, ".hht"}, hht, popped < N);
    end
    check({tag, ".all_popped"}, popped, N);
  endtask

  initial begin
    wdata_col_base = COL_BASE;
    v_values_base  = V_BASE;
    csize          = N;
    RD             = 1'b1;
    cpu_addr       = 32'd126;
    Rst            = 1'b0;
    load_mem();

    // Reset state
    tick();
    check_zero("reset");

    // Continuous read with exact pipeline timing
    do_reset();
    tick();
    check("e1.addr1", addr1, 180);
    check("e1.hht", hht, 1);
    tick();
    check("e2.addr2", addr2, 17);
    check("e2.addr1", addr1, 181);
    tick();
    check("e3.rdata", rdata, 0);
    tick();
    check("e4.rdata", rdata, 34);
    check("e4.adata", adata, 15);
    check("e4.regaddr1", regaddr1, 180);
    check("e4.regaddr2", regaddr2, 17);
    tick();
    check("e5.rdata", rdata, 68);
    check("e5.adata", adata, 2);
    check("e5.regaddr1", regaddr1, 181);
    check("e5.regaddr2", regaddr2, 4);
    tick();
    check("e6.rdata", rdata, 52);
    check("e6.adata", adata, 11);
    check("e6.regaddr1", regaddr1, 182);
    check("e6.regaddr2", regaddr2, 13);
    for (int k = 3; k < N; k++) begin
      tick();
      check_elem("cont", k);
      check("cont.hht", hht, k < N - 1);
    end
    check("last.rdata", rdata, 80);
    check("last.adata", adata, 3);
    check("last.regaddr1", regaddr1, 409);
    check("last.regaddr2", regaddr2, 5);
    tick();
    check("done.hold", regaddr1, 409);
    check("done.hht", hht, 0);

    // Stalled consumer
    RD = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    check("stall.addr1", addr1, 189);
    check("stall.hht", hht, 1);
    check("stall.rdata", rdata, 0);
    RD = 1'b1;
    tick();
    check("resume.rdata", rdata, 34);
    check("resume.regaddr1", regaddr1, 180);
    drain("stall", 1, 100, 0);

    // Wrong address: nothing pops
    RD = 1'b1;
    cpu_addr = 32'd125;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    check("wrong.rdata", rdata, 0);
    check("wrong.adata", adata, 0);
    check("wrong.regaddr1", regaddr1, 0);
    check("wrong.regaddr2", regaddr2, 0);
    check("wrong.hht", hht, 1);

    // Zero size
    csize = 0;
    cpu_addr = 32'd126;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("zero.hht", hht, 0);
    end
    check_zero("zero");

    // Reset mid-run after 50 pops
    csize = N;
    do_reset();
    for (int i = 0; i < 53; i++) tick();
    check("mid.regaddr1", regaddr1, 180 + 49);
    #2 Rst = 1'b0;
    #1 check_zero("mid_reset");
    tick();
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("restart.rdata", rdata, 34);
    check("restart.regaddr1", regaddr1, 180);

    // Randomized indices, one out-of-range index, randomized consumer
    load_mem();
    mem[COL_BASE + OOR_K] = 32'd1000;
    oor_seen = '0;
    do_reset();
    drain("rand", 0, 70, 10);
    check("oor.rdata", oor_seen, 99999);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
